// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of one shared unified memory
//
// Two requesters (instruction fetch, data load/store) share one memory that
// accepts a single outstanding command. Accepted requests are latched in IDLE,
// issued as a one-cycle m_en strobe in ISSUE, and completed in WAIT on m_valid
// or on timeout. Completion is reported one cycle later as a ready pulse on
// the owning port.
//
// Ports:
//   clock, reset_n                    clock, synchronous active-low reset
//   if_req, if_addr                   fetch read request
//   if_rdata, if_ready                fetch completion data and pulse
//   dm_req, dm_we, dm_addr, dm_wdata  data load/store request
//   dm_rdata, dm_ready                data completion data and pulse
//   m_en, m_we, m_addr, m_wdata       memory command (m_en one cycle wide)
//   m_rdata, m_valid                  memory response
//   err                               high with the ready of a timed-out access
//   busy                              high whenever an access is in flight
//
// Build option:
//   MEM_ARBITER_RR_EN  ties alternate between the ports using a last-grant
//                      register; when undefined the data port wins every tie.

module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_valid,
    output logic          err,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Counter value reached on the last WAIT cycle before the access is
    // declared timed out.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;      // 1 = data port, 0 = fetch port
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;
    logic          err_q, err_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
`ifdef MEM_ARBITER_RR_EN
    logic          last_q, last_d;        // 1 = data port granted last
`endif

    logic if_elig;
    logic dm_elig;
    logic tie_data;
    logic grant_data;
    logic done;
    logic timed_out;

    // A port whose ready is high this cycle is dropping its request, so it
    // must not be granted again off the stale level.
    assign if_elig = if_req & ~if_ready_q;
    assign dm_elig = dm_req & ~dm_ready_q;

`ifdef MEM_ARBITER_RR_EN
    assign tie_data = ~last_q;
`else
    assign tie_data = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARBITER_RR_EN
        last_d     = last_q;
`endif
        grant_data = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_elig || dm_elig) begin
                    grant_data = (if_elig && dm_elig) ? tie_data : dm_elig;
                    owner_d    = grant_data;
                    we_d       = grant_data & dm_we;
                    addr_d     = grant_data ? dm_addr : if_addr;
                    wdata_d    = grant_data ? dm_wdata : '0;
`ifdef MEM_ARBITER_RR_EN
                    last_d     = grant_data;
`endif
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response arriving on the final timeout cycle still wins.
                if (m_valid) begin
                    done = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done) begin
            state_d = S_IDLE;
            err_d   = timed_out;
            if (owner_q) begin
                dm_ready_d = 1'b1;
                dm_rdata_d = (timed_out || we_q) ? '0 : m_rdata;
            end else begin
                if_ready_d = 1'b1;
                if_rdata_d = timed_out ? '0 : m_rdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= 8'd0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARBITER_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign m_en     = (state_q == S_ISSUE);
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign if_ready = if_ready_q;
    assign dm_ready = dm_ready_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_valid = 1'b0;
    logic        err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: memory contents, last completed data per port and
    // which port was granted most recently.
    logic [31:0] mem_model [16];
    logic [31:0] last_if_rd = '0;
    logic [31:0] last_dm_rd = '0;
    bit          last_grant_data = 1'b0;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_valid  (m_valid),
        .err      (err),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit tie_winner_is_data();
`ifdef MEM_ARBITER_RR_EN
        return !last_grant_data;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_en"}, m_en, 0);
        chk({tag, "_m_we"}, m_we, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_wdata"}, m_wdata, 0);
        chk({tag, "_readies"}, {if_ready, dm_ready}, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Acts as the memory for one access: expects the command one cycle after
    // the call, answers lat cycles after m_en (lat = 0: never answers) and
    // checks the completion on the owning port.
    task automatic serve(input bit is_data, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
        int          waited;
        bit          seen;
        int          idx;
        int          n;
        logic [31:0] resp;
        logic [31:0] exp_rd;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 6) begin
            step();
            waited++;
            if (m_en === 1'b1) seen = 1'b1;
        end
        chk("m_en_latency", waited, 1);
        last_grant_data = is_data;
        chk("cmd_we", m_we, is_data && we);
        chk("cmd_addr", m_addr, addr);
        if (is_data && we) chk("cmd_wdata", m_wdata, wdata);
        chk("cmd_busy", busy, 1);

        idx = int'(addr[5:2]);
        if (we) begin
            mem_model[idx] = wdata;
            resp   = $urandom;
            exp_rd = '0;
        end else begin
            resp   = mem_model[idx];
            exp_rd = resp;
        end
        if (lat == 0) exp_rd = '0;

        n = (lat > 0) ? lat : TIMEOUT;
        for (int i = 0; i < n; i++) begin
            step();
            chk("wait_no_ready", {if_ready, dm_ready}, 0);
            chk("wait_busy", busy, 1);
            chk("wait_no_m_en", m_en, 0);
        end
        if (lat > 0) begin
            m_valid = 1'b1;
            m_rdata = resp;
        end
        step();
        m_valid = 1'b0;
        m_rdata = $urandom;

        chk("done_if_ready", if_ready, !is_data);
        chk("done_dm_ready", dm_ready, is_data);
        chk("done_err", err, lat == 0);
        chk("done_busy", busy, 0);
        if (is_data) begin
            chk("done_dm_rdata", dm_rdata, exp_rd);
            chk("hold_if_rdata", if_rdata, last_if_rd);
            last_dm_rd = exp_rd;
            dm_req = 1'b0;
        end else begin
            chk("done_if_rdata", if_rdata, exp_rd);
            chk("hold_dm_rdata", dm_rdata, last_dm_rd);
            last_if_rd = exp_rd;
            if_req = 1'b0;
        end
    endtask

    initial begin
        bit          pick_data;
        int          pat;
        int          lat_i;
        int          lat_d;
        logic [31:0] a_i;
        logic [31:0] a_d;
        logic [31:0] wd;
        bit          we_r;

        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;

        // Reset state.
        reset_n = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();

        // m_valid while IDLE must be ignored.
        m_valid = 1'b1;
        step();
        m_valid = 1'b0;
        step();
        chk("idle_mvalid_readies", {if_ready, dm_ready}, 0);
        chk("idle_mvalid_busy", busy, 0);

        // Fetch of 0x40, memory answers two cycles after m_en.
        mem_model[0] = 32'h8C01_0004;
        if_addr = 32'h0000_0040;
        if_req  = 1'b1;
        serve(1'b0, 1'b0, 32'h0000_0040, '0, 2);
        chk("fetch_rdata_value", if_rdata, 32'h8C01_0004);
        step();
        chk("pulse_one_cycle", {if_ready, dm_ready, err}, 0);
        chk("no_regrant", m_en, 0);

        // Store 0xDEADBEEF to 0x200.
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0200;
        dm_wdata = 32'hDEAD_BEEF;
        dm_req   = 1'b1;
        serve(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1);
        step();

        // Repeated ties: fetch and a load of 0x100 raised together.
        for (int t = 0; t < 2; t++) begin
            if_addr = 32'h0000_0080 + 32'(t * 4);
            dm_we   = 1'b0;
            dm_addr = 32'h0000_0100;
            if_req  = 1'b1;
            dm_req  = 1'b1;
            pick_data = tie_winner_is_data();
            chk("tie_model_data_first", pick_data, 1);
            serve(1'b1, 1'b0, 32'h0000_0100, '0, 1 + t);
            serve(1'b0, 1'b0, if_addr, '0, 2);
            step();
        end

        // Timeouts on both ports.
        if_addr = 32'h0000_0048;
        if_req  = 1'b1;
        serve(1'b0, 1'b0, 32'h0000_0048, '0, 0);
        step();
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0104;
        dm_req  = 1'b1;
        serve(1'b1, 1'b0, 32'h0000_0104, '0, 0);
        step();

        // Reset while WAITing, late m_valid after release.
        if_addr = 32'h0000_0044;
        if_req  = 1'b1;
        step();
        chk("rst_issue_m_en", m_en, 1);
        step();
        reset_n = 1'b0;
        if_req  = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        m_valid = 1'b1;
        m_rdata = 32'h1234_5678;
        step();
        m_valid = 1'b0;
        check_reset_outputs("rst_wait_a");
        step();
        check_reset_outputs("rst_wait_b");
        last_if_rd      = '0;
        last_dm_rd      = '0;
        last_grant_data = 1'b0;

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            step();
            chk("rand_idle_readies", {if_ready, dm_ready, err}, 0);
            pat   = $urandom_range(0, 2);
            a_i   = $urandom & 32'hFFFF_FFFC;
            a_d   = $urandom & 32'hFFFF_FFFC;
            wd    = $urandom;
            we_r  = $urandom_range(0, 1);
            lat_i = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            lat_d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            if_addr  = a_i;
            dm_addr  = a_d;
            dm_wdata = wd;
            dm_we    = we_r;
            if (pat == 0) begin
                if_req = 1'b1;
                serve(1'b0, 1'b0, a_i, '0, lat_i);
            end else if (pat == 1) begin
                dm_req = 1'b1;
                serve(1'b1, we_r, a_d, wd, lat_d);
            end else begin
                if_req = 1'b1;
                dm_req = 1'b1;
                pick_data = tie_winner_is_data();
                if (pick_data) begin
                    serve(1'b1, we_r, a_d, wd, lat_d);
                    serve(1'b0, 1'b0, a_i, '0, lat_i);
                end else begin
                    serve(1'b0, 1'b0, a_i, '0, lat_i);
                    serve(1'b1, we_r, a_d, wd, lat_d);
                end
            end
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
